// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants for the intersection signal-head logic.
//   - phase codes issued by the intersection controller FSM
//   - lamp bit positions within a 4-bit signal head
//   - sticky fault_code encodings
//   - driver FSM state type and a small phase-classification helper
package traffic_pkg;

  // Phase codes, in the order the controller is allowed to step through them.
  localparam logic [2:0] PhNGreen  = 3'd0;
  localparam logic [2:0] PhNYellow = 3'd1;
  localparam logic [2:0] PhRed1    = 3'd2;
  localparam logic [2:0] PhELeft   = 3'd3;
  localparam logic [2:0] PhEGreen  = 3'd4;
  localparam logic [2:0] PhEYellow = 3'd5;
  localparam logic [2:0] PhRed2    = 3'd6;
  localparam logic [2:0] PhNLeft   = 3'd7;

  // Bit positions within one signal head.
  localparam int unsigned LampRed    = 0;
  localparam int unsigned LampYellow = 1;
  localparam int unsigned LampGreen  = 2;
  localparam int unsigned LampLeft   = 3;

  // A head showing only its red lamp.
  localparam logic [3:0] LampsRedOnly = 4'b0001;

  // fault_code encodings.
  localparam logic [1:0] FaultNone  = 2'b00;
  localparam logic [1:0] FaultJump  = 2'b01;
  localparam logic [1:0] FaultClear = 2'b10;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFault = 1'b1
  } drv_state_e;

  // True for the all-red clearance phases that must be held a minimum time.
  function automatic logic is_clearance(input logic [2:0] code);
    return (code == PhRed1) || (code == PhRed2);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// blink_timer: half-period timer for fault flashing.
//   clk    - rising-edge clock
//   resetn - synchronous active-low reset
//   clear  - holds the counter and phase at zero while high
//   phase  - 0 during the lit half-period, 1 during the dark half-period
// The counter runs 0..BLINK_HALF-1 and toggles phase each time it wraps.
module blink_timer #(
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic phase
);

  localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_HALF - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/signal_head_driver.sv
// signal_head_driver: converts the controller's phase code into lamp drives for the
// north and east signal heads, and watches the phase sequence for illegal jumps and
// short all-red clearances. Any violation latches a flashing all-red fault mode that
// only reset can leave.
//   clk        - rising-edge clock
//   resetn     - synchronous active-low reset
//   phase_code - controller phase code (see traffic_pkg)
//   lamps_n    - north head {left, green, yellow, red}
//   lamps_e    - east head, same bit order
//   fault      - sticky sequence-fault flag
//   fault_code - sticky cause: 01 illegal jump, 10 short clearance
// phase_code is registered into code_q, then decoded into registered lamp outputs,
// so lamps follow phase_code by two cycles.
module signal_head_driver
  import traffic_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 25000000,
  parameter int unsigned MIN_CLEAR  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] phase_code,
  output logic [3:0] lamps_n,
  output logic [3:0] lamps_e,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned DwellW = (MIN_CLEAR > 0) ? $clog2(MIN_CLEAR + 1) : 1;
  localparam logic [DwellW-1:0] DwellMax = DwellW'(MIN_CLEAR);

  drv_state_e        state_q, state_d;
  logic [2:0]        code_q;
  logic [2:0]        prev_code;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [3:0]        lamps_n_q, lamps_n_d;
  logic [3:0]        lamps_e_q, lamps_e_d;
  logic [1:0]        fault_code_q, fault_code_d;

  logic [3:0] dec_n, dec_e;
  logic       step_same, step_next;
  logic       bad_jump, short_clear;
  logic       blink_off;

  // ---------------------------------------------------------------------------
  // Lamp decode of the registered phase code.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_n = '0;
    dec_e = '0;
    unique case (code_q)
      PhNGreen: begin
        dec_n[LampGreen] = 1'b1;
        dec_e[LampRed]   = 1'b1;
      end
      PhNYellow: begin
        dec_n[LampYellow] = 1'b1;
        dec_e[LampRed]    = 1'b1;
      end
      PhRed1, PhRed2: begin
        dec_n[LampRed] = 1'b1;
        dec_e[LampRed] = 1'b1;
      end
      PhELeft: begin
        dec_n[LampRed]  = 1'b1;
        dec_e[LampRed]  = 1'b1;
        dec_e[LampLeft] = 1'b1;
      end
      PhEGreen: begin
        dec_n[LampRed]   = 1'b1;
        dec_e[LampGreen] = 1'b1;
      end
      PhEYellow: begin
        dec_n[LampRed]    = 1'b1;
        dec_e[LampYellow] = 1'b1;
      end
      PhNLeft: begin
        dec_n[LampRed]  = 1'b1;
        dec_n[LampLeft] = 1'b1;
        dec_e[LampRed]  = 1'b1;
      end
      default: begin
        dec_n[LampRed] = 1'b1;
        dec_e[LampRed] = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequence checker: holding a code or advancing by one (7 wraps to 0) is legal.
  // dwell counts how many consecutive cycles prev_code has been held.
  // ---------------------------------------------------------------------------
  always_comb begin
    step_same   = (code_q == prev_code);
    step_next   = (code_q == (prev_code + 3'd1));
    bad_jump    = !(step_same || step_next);
    short_clear = step_next && is_clearance(prev_code) && (dwell_q < DwellMax);

    dwell_d = dwell_q;
    if (!step_same) begin
      dwell_d = DwellW'(1);
    end else if (dwell_q < DwellMax) begin
      dwell_d = dwell_q + DwellW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver FSM and registered outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    lamps_n_d    = lamps_n_q;
    lamps_e_d    = lamps_e_q;

    unique case (state_q)
      StRun: begin
        if (bad_jump || short_clear) begin
          // Illegal jump outranks a short clearance.
          state_d      = StFault;
          fault_code_d = bad_jump ? FaultJump : FaultClear;
          lamps_n_d    = LampsRedOnly;
          lamps_e_d    = LampsRedOnly;
        end else begin
          lamps_n_d = dec_n;
          lamps_e_d = dec_e;
        end
      end
      StFault: begin
        lamps_n_d          = '0;
        lamps_e_d          = '0;
        lamps_n_d[LampRed] = ~blink_off;
        lamps_e_d[LampRed] = ~blink_off;
      end
      default: begin
        state_d = StFault;
      end
    endcase
  end

  // The timer starts counting on the entry edge itself, so the lit entry cycle is
  // the first of the BLINK_HALF lit cycles.
  blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink_timer (
    .clk   (clk),
    .resetn(resetn),
    .clear (state_d == StRun),
    .phase (blink_off)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StRun;
      code_q       <= PhNGreen;
      prev_code    <= PhNGreen;
      dwell_q      <= DwellW'(1);
      lamps_n_q    <= LampsRedOnly;
      lamps_e_q    <= LampsRedOnly;
      fault_code_q <= FaultNone;
    end else begin
      state_q      <= state_d;
      code_q       <= phase_code;
      prev_code    <= code_q;
      dwell_q      <= dwell_d;
      lamps_n_q    <= lamps_n_d;
      lamps_e_q    <= lamps_e_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign lamps_n    = lamps_n_q;
  assign lamps_e    = lamps_e_q;
  assign fault      = (state_q == StFault);
  assign fault_code = fault_code_q;

endmodule
